// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall bus layout, FSM
// encodings, exception vector and the stall hold patterns.
package pipe_ctrl_pkg;

  localparam int STALL_BUS_W = 5;
  typedef logic [STALL_BUS_W-1:0] stall_bus_t;  // STALL_BUS (4:0)

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUS = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [31:0] EXC_HANDLER_ADDR = 32'hBFC0_0380;

  // Bit i holds stage i; a 1 followed by a 0 injects a bubble after stage i.
  localparam stall_bus_t STALL_ALL  = 5'b11111;
  localparam stall_bus_t STALL_EXE  = 5'b00111;
  localparam stall_bus_t STALL_ID   = 5'b00011;
  localparam stall_bus_t STALL_IF   = 5'b00001;
  localparam stall_bus_t STALL_NONE = 5'b00000;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall encoder and exception redirect FSM for the 5-stage core.
// Optional stall performance counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        id_stallreq,
  input  logic        exe_stallreq,
  input  logic        exc_valid,
  input  logic        exc_eret,
  input  logic [31:0] cp0_epc,
  output logic [4:0]  stall,
  output logic        mem_stop_wb,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles
);

  state_e      state_r;
  state_e      next_state_s;
  logic [31:0] target_r;
  logic [31:0] next_target_s;
  logic        flush_r;
  logic [31:0] new_pc_r;
  stall_bus_t  stall_s;
  logic        bus_idle_s;

  assign bus_idle_s = !if_busy && !mem_busy;

  // Next-state and redirect-target capture; only IDLE accepts a new exception.
  always_comb begin
    next_state_s  = state_r;
    next_target_s = target_r;
    case (state_r)
      IDLE: begin
        if (exc_valid) begin
          next_target_s = exc_eret ? cp0_epc : EXC_HANDLER_ADDR;
          next_state_s  = bus_idle_s ? FLUSH : WAIT_BUS;
        end else begin
          next_state_s  = IDLE;
        end
      end
      WAIT_BUS: begin
        if (bus_idle_s) begin
          next_state_s = FLUSH;
        end else begin
          next_state_s = WAIT_BUS;
        end
      end
      FLUSH:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, target and registered redirect outputs, valid exactly in FLUSH.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_r  <= IDLE;
      target_r <= 32'h0;
      flush_r  <= 1'b0;
      new_pc_r <= 32'h0;
    end else begin
      state_r  <= next_state_s;
      target_r <= next_target_s;
      flush_r  <= (next_state_s == FLUSH);
      new_pc_r <= (next_state_s == FLUSH) ? next_target_s : 32'h0;
    end
  end

  // Stall priority encoder; a pending redirect freezes the whole pipe.
  always_comb begin
    stall_s = STALL_NONE;
    if (!cpu_rst_n) begin
      stall_s = STALL_NONE;
    end else if (state_r != IDLE) begin
      stall_s = STALL_ALL;
    end else if (mem_busy) begin
      stall_s = STALL_ALL;
    end else if (exe_stallreq) begin
      stall_s = STALL_EXE;
    end else if (id_stallreq) begin
      stall_s = STALL_ID;
    end else if (if_busy) begin
      stall_s = STALL_IF;
    end else begin
      stall_s = STALL_NONE;
    end
  end

  assign stall       = stall_s;
  assign mem_stop_wb = stall_s[4];
  assign flush       = flush_r;
  assign new_pc      = new_pc_r;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Count every edge on which any stage is held; wraps naturally at 2^32.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      stall_cnt_r <= 32'h0;
    end else if (stall_s != STALL_NONE) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; each scenario task checks inline.
module tb_pipe_ctrl;

  logic        cpu_clk_50M;
  logic        cpu_rst_n;
  logic        if_busy;
  logic        mem_busy;
  logic        id_stallreq;
  logic        exe_stallreq;
  logic        exc_valid;
  logic        exc_eret;
  logic [31:0] cp0_epc;
  logic [4:0]  stall;
  logic        mem_stop_wb;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .if_busy     (if_busy),
    .mem_busy    (mem_busy),
    .id_stallreq (id_stallreq),
    .exe_stallreq(exe_stallreq),
    .exc_valid   (exc_valid),
    .exc_eret    (exc_eret),
    .cp0_epc     (cp0_epc),
    .stall       (stall),
    .mem_stop_wb (mem_stop_wb),
    .flush       (flush),
    .new_pc      (new_pc),
    .stall_cycles(stall_cycles)
  );

  initial cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic idle_inputs();
    if_busy = 1'b0; mem_busy = 1'b0; id_stallreq = 1'b0; exe_stallreq = 1'b0;
    exc_valid = 1'b0; exc_eret = 1'b0; cp0_epc = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_busy  = 1'b1;
    cpu_rst_n = 1'b0;
    #5;
    checks++; if (stall !== 5'b00000) begin errors++; $display("FAIL reset_stall got %b exp %b", stall, 5'b00000); end
    checks++; if (mem_stop_wb !== 1'b0) begin errors++; $display("FAIL reset_mem_stop_wb got %b exp 0", mem_stop_wb); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got %h exp 0", new_pc); end
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); end
    step();
    mem_busy  = 1'b0;
    cpu_rst_n = 1'b1;
    step();
  endtask

  task automatic test_id_stall();
    id_stallreq = 1'b1;
    #1;
    checks++; if (stall !== 5'b00011) begin errors++; $display("FAIL id_stall got %b exp %b", stall, 5'b00011); end
    step();
    id_stallreq = 1'b0;
    #1;
    checks++; if (stall !== 5'b00000) begin errors++; $display("FAIL id_stall_release got %b exp %b", stall, 5'b00000); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL id_stall_flush got %b exp 0", flush); end
    step();
  endtask

  task automatic test_exe_if();
    exe_stallreq = 1'b1; if_busy = 1'b1;
    #1;
    checks++; if (stall !== 5'b00111) begin errors++; $display("FAIL exe_if got %b exp %b", stall, 5'b00111); end
    step();
    exe_stallreq = 1'b0;
    #1;
    checks++; if (stall !== 5'b00001) begin errors++; $display("FAIL if_only got %b exp %b", stall, 5'b00001); end
    step();
    if_busy = 1'b0;
    step();
  endtask

  task automatic test_mem_busy();
    for (int i = 0; i < 4; i++) begin
      mem_busy = 1'b1; id_stallreq = (i == 1);
      #1;
      checks++; if (stall !== 5'b11111) begin errors++; $display("FAIL mem_busy_stall[%0d] got %b exp %b", i, stall, 5'b11111); end
      checks++; if (mem_stop_wb !== 1'b1) begin errors++; $display("FAIL mem_busy_wb[%0d] got %b exp 1", i, mem_stop_wb); end
      step();
    end
    mem_busy = 1'b0; id_stallreq = 1'b0;
    #1;
    checks++; if (stall !== 5'b00000) begin errors++; $display("FAIL mem_busy_end got %b exp %b", stall, 5'b00000); end
    checks++; if (mem_stop_wb !== 1'b0) begin errors++; $display("FAIL mem_busy_end_wb got %b exp 0", mem_stop_wb); end
    step();
  endtask

  task automatic test_exc_handler();
    exc_valid = 1'b1; exc_eret = 1'b0; cp0_epc = 32'h1111_1111;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL exc_flush_early got %b exp 0", flush); end
    step();
    exc_valid = 1'b0;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL exc_flush got %b exp 1", flush); end
    checks++; if (new_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL exc_new_pc got %h exp %h", new_pc, 32'hBFC0_0380); end
    checks++; if (stall !== 5'b11111) begin errors++; $display("FAIL exc_flush_stall got %b exp %b", stall, 5'b11111); end
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL exc_flush_one_cycle got %b exp 0", flush); end
    checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL exc_new_pc_clear got %h exp 0", new_pc); end
    checks++; if (stall !== 5'b00000) begin errors++; $display("FAIL exc_back_idle got %b exp %b", stall, 5'b00000); end
    step();
  endtask

  task automatic test_eret_wait();
    exc_valid = 1'b1; exc_eret = 1'b1; cp0_epc = 32'h8000_1234; mem_busy = 1'b1;
    step();
    // Second exception while waiting must not replace the captured EPC.
    exc_valid = 1'b1; exc_eret = 1'b0; cp0_epc = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) exc_valid = 1'b0;
      if (i == 2) mem_busy = 1'b0;
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL wait_flush[%0d] got %b exp 0", i, flush); end
      checks++; if (stall !== 5'b11111) begin errors++; $display("FAIL wait_stall[%0d] got %b exp %b", i, stall, 5'b11111); end
      step();
    end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL eret_flush got %b exp 1", flush); end
    checks++; if (new_pc !== 32'h8000_1234) begin errors++; $display("FAIL eret_new_pc got %h exp %h", new_pc, 32'h8000_1234); end
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL eret_flush_end got %b exp 0", flush); end
    idle_inputs();
    step();
  endtask

  task automatic test_exc_priority();
    exe_stallreq = 1'b1; exc_valid = 1'b1; exc_eret = 1'b0;
    #1;
    checks++; if (stall !== 5'b00111) begin errors++; $display("FAIL prio_same_cycle got %b exp %b", stall, 5'b00111); end
    step();
    exc_valid = 1'b0;
    #1;
    checks++; if (stall !== 5'b11111) begin errors++; $display("FAIL prio_flush_stall got %b exp %b", stall, 5'b11111); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL prio_flush got %b exp 1", flush); end
    step();
    exe_stallreq = 1'b0;
    step();
  endtask

  task automatic test_reset_wait();
    exc_valid = 1'b1; exc_eret = 1'b1; cp0_epc = 32'h8000_4000; if_busy = 1'b1;
    step();
    exc_valid = 1'b0;
    #1;
    checks++; if (stall !== 5'b11111) begin errors++; $display("FAIL rstwait_pre got %b exp %b", stall, 5'b11111); end
    cpu_rst_n = 1'b0;
    #2;
    checks++; if (stall !== 5'b00000) begin errors++; $display("FAIL rstwait_stall got %b exp %b", stall, 5'b00000); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstwait_flush got %b exp 0", flush); end
    step();
    if_busy   = 1'b0;
    cpu_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstwait_no_flush[%0d] got %b exp 0", i, flush); end
      checks++; if (stall !== 5'b00000) begin errors++; $display("FAIL rstwait_idle[%0d] got %b exp %b", i, stall, 5'b00000); end
    end
  endtask

  task automatic test_counter();
    logic [31:0] exp_n;
    cpu_rst_n = 1'b0;
    #2;
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL cnt_reset got %0d exp 0", stall_cycles); end
    step();
    cpu_rst_n = 1'b1;
    step();
    id_stallreq = 1'b1;
    step(); step(); step();
    id_stallreq = 1'b0;
    step(); step();
`ifdef PIPE_STALL_CNT_EN
    exp_n = 32'd3;
`else
    exp_n = 32'd0;
`endif
    checks++; if (stall_cycles !== exp_n) begin errors++; $display("FAIL cnt_value got %0d exp %0d", stall_cycles, exp_n); end
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    idle_inputs();
    #3;
    test_reset();
    test_id_stall();
    test_exe_if();
    test_mem_busy();
    test_exc_handler();
    test_eret_wait();
    test_exc_priority();
    test_reset_wait();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: ports cpu_clk_50M and cpu_rst_n.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- cpu_clk_50M  in  1  core clock.
- cpu_rst_n  in  1  asynchronous active-low reset.
- if_busy  in  1  instruction fetch AXI transaction outstanding.
- mem_busy  in  1  data AXI transaction outstanding.
- id_stallreq  in  1  load-use interlock request from decode.
- exe_stallreq  in  1  multi-cycle unit (mult/div) busy.
- exc_valid  in  1  exception or ERET committed in the MEM stage.
- exc_eret  in  1  qualifies exc_valid as ERET.
- cp0_epc  in  32  EPC value from CP0.
- stall  out  5  hold enables: [0] pc, [1] if/id, [2] id/exe, [3] exe/mem, [4] mem/wb.
- mem_stop_wb  out  1  freezes the mem/wb register and masks its outputs.
- flush  out  1  clears all pipeline registers.
- new_pc  out  32  redirect target, valid while flush=1.
- stall_cycles  out  32  stall performance counter.

Function
REQ-003 stall SHALL be combinational from the inputs and the state, with priority in this order:
- FSM not in IDLE: 5'b11111.
- mem_busy: 5'b11111.
- exe_stallreq: 5'b00111.
- id_stallreq: 5'b00011.
- if_busy: 5'b00001.
- otherwise: 5'b00000.
REQ-004 When stall[i]=1 and stall[i+1]=0, the register following stage i SHALL receive a bubble; the pipeline registers implement the bubble, and this block only encodes it in stall.
REQ-005 mem_stop_wb SHALL equal stall[4].
REQ-006 The FSM SHALL have three states: IDLE, WAIT_BUS and FLUSH.
REQ-007 In IDLE with exc_valid=1, the block SHALL capture target = exc_eret ? cp0_epc : 32'hBFC00380 into a register.
REQ-008 From that IDLE capture, the FSM SHALL go to FLUSH if if_busy=0 and mem_busy=0, and otherwise to WAIT_BUS.
REQ-009 WAIT_BUS SHALL stay until if_busy=0 and mem_busy=0 in the same cycle, then go to FLUSH.
REQ-010 FLUSH SHALL last exactly one cycle, drive flush=1 and new_pc=target, then return to IDLE.
REQ-011 flush and new_pc SHALL be registered outputs: flush rises one cycle after exc_valid when both buses are idle, and never while either busy input is 1.
REQ-012 exc_valid asserted in WAIT_BUS or FLUSH SHALL be ignored; the target captured first SHALL be kept.
REQ-013 Outside FLUSH, new_pc SHALL be 32'h0.
REQ-014 If an exception and exe_stallreq occur in the same cycle, the exception SHALL win: the FSM leaves IDLE and the stall rule for non-IDLE states applies.

Reset
REQ-015 Asserting cpu_rst_n=0 SHALL immediately force state=IDLE, flush=0, new_pc=0, target=0 and stall_cycles=0.
REQ-016 While cpu_rst_n=0, stall SHALL be 5'b00000 and mem_stop_wb SHALL be 0.
REQ-017 A reset that arrives in WAIT_BUS or FLUSH SHALL discard the pending redirect.

Configuration
REQ-018 With PIPE_STALL_CNT_EN defined, stall_cycles SHALL increment by 1, wrapping at 2^32, on every clock edge where stall is non-zero and cpu_rst_n=1.
REQ-019 Without PIPE_STALL_CNT_EN, stall_cycles SHALL be constant 0 and no counter register SHALL be synthesised; the port list is unchanged.

Structure
REQ-020 The following SHALL live in the shared defines file: STALL_BUS (4:0), FSM state encodings, EXC_HANDLER_ADDR (32'hBFC00380), and the stall pattern constants.
REQ-021 The block SHALL be a single module; the stall priority encoder and the FSM are not split out.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- id_stallreq=1 for 1 cycle, all else 0 -> stall=5'b00011 that cycle, then 5'b00000; flush stays 0.
- exe_stallreq=1 and if_busy=1 together -> stall=5'b00111.
- mem_busy=1 for 4 cycles -> stall=5'b11111 and mem_stop_wb=1 for exactly those 4 cycles.
- exc_valid=1 with exc_eret=0 and buses idle -> next cycle flush=1 and new_pc=32'hBFC00380 for 1 cycle; stall=5'b11111 during FLUSH.
- exc_valid=1 with exc_eret=1, cp0_epc=32'h8000_1234 and mem_busy=1 for 3 more cycles -> WAIT_BUS for 3 cycles, then flush=1 and new_pc=32'h8000_1234; a second exc_valid during WAIT_BUS is ignored.
- Reset asserted mid-WAIT_BUS -> flush stays 0 and state=IDLE; with PIPE_STALL_CNT_EN, stall_cycles=0 after reset, and stall_cycles=N after N stalled cycles.
